// File: rtl/bitonic_pkg.sv
// Shared types and the compare-exchange primitive for the bitonic merge pipeline.
package bitonic_pkg;

  localparam int MAX_DEPTH    = 6;
  localparam int KEY_MAX_BITS = 64;

  typedef enum logic {
    DIR_ASC  = 1'b0,
    DIR_DESC = 1'b1
  } dir_e;

  typedef logic [KEY_MAX_BITS-1:0] key_t;

  typedef struct packed {
    key_t lo;
    key_t hi;
  } key_pair_t;

  // Equal keys never swap, so the lower index keeps its original element.
  function automatic key_pair_t cmp_swap(input key_t a, input key_t b, input dir_e dir);
    key_pair_t pair;
    logic      swap;
    swap    = (dir == DIR_ASC) ? (a > b) : (a < b);
    pair.lo = swap ? b : a;
    pair.hi = swap ? a : b;
    return pair;
  endfunction

endpackage

// File: rtl/bitonic_merge_stage.sv
// One half-cleaner layer of the bitonic merger followed by its pipeline register.
// Payload lanes exist only when BITONIC_MERGE_PAYLOAD_EN is defined.
module bitonic_merge_stage
  import bitonic_pkg::*;
#(
  parameter int VALUE_BITS = 8,
  parameter int SIZE       = 8,
  parameter int HALF       = 4
`ifdef BITONIC_MERGE_PAYLOAD_EN
  ,
  parameter int PAYLOAD_BITS = 8
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic                         in_dir,
  input  logic [SIZE*VALUE_BITS-1:0]   in_key,
`ifdef BITONIC_MERGE_PAYLOAD_EN
  input  logic [SIZE*PAYLOAD_BITS-1:0] in_payload,
  output logic [SIZE*PAYLOAD_BITS-1:0] out_payload,
`endif
  output logic                         out_valid,
  output logic                         out_dir,
  output logic [SIZE*VALUE_BITS-1:0]   out_key
);

  logic [SIZE*VALUE_BITS-1:0] key_next;
  logic [SIZE*VALUE_BITS-1:0] key_reg;
  logic                       valid_reg;
  logic                       dir_reg;
`ifdef BITONIC_MERGE_PAYLOAD_EN
  logic [SIZE*PAYLOAD_BITS-1:0] payload_next;
  logic [SIZE*PAYLOAD_BITS-1:0] payload_reg;
`endif

  for (genvar gi = 0; gi < SIZE / 2; gi++) begin : g_cx
    // Pair gi maps to element LO of its 2*HALF block and its partner HALF above.
    localparam int LO = (gi / HALF) * 2 * HALF + (gi % HALF);
    localparam int HI = LO + HALF;

    key_t      key_lo;
    key_t      key_hi;
    key_pair_t pair;

    assign key_lo = key_t'(in_key[LO*VALUE_BITS +: VALUE_BITS]);
    assign key_hi = key_t'(in_key[HI*VALUE_BITS +: VALUE_BITS]);
    assign pair   = cmp_swap(key_lo, key_hi, dir_e'(in_dir));

    assign key_next[LO*VALUE_BITS +: VALUE_BITS] = pair.lo[VALUE_BITS-1:0];
    assign key_next[HI*VALUE_BITS +: VALUE_BITS] = pair.hi[VALUE_BITS-1:0];

    if (VALUE_BITS < KEY_MAX_BITS) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^{pair.lo[KEY_MAX_BITS-1:VALUE_BITS],
                            pair.hi[KEY_MAX_BITS-1:VALUE_BITS]};
    end

`ifdef BITONIC_MERGE_PAYLOAD_EN
    logic swapped;
    assign swapped = (pair.lo != key_lo);
    assign payload_next[LO*PAYLOAD_BITS +: PAYLOAD_BITS] = swapped ?
        in_payload[HI*PAYLOAD_BITS +: PAYLOAD_BITS] : in_payload[LO*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign payload_next[HI*PAYLOAD_BITS +: PAYLOAD_BITS] = swapped ?
        in_payload[LO*PAYLOAD_BITS +: PAYLOAD_BITS] : in_payload[HI*PAYLOAD_BITS +: PAYLOAD_BITS];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (en) begin
      valid_reg <= in_valid;
    end
  end

  // Data lanes carry no reset; only the valid bit decides whether they matter.
  always_ff @(posedge clk) begin
    if (en) begin
      dir_reg     <= in_dir;
      key_reg     <= key_next;
`ifdef BITONIC_MERGE_PAYLOAD_EN
      payload_reg <= payload_next;
`endif
    end
  end

  assign out_valid   = valid_reg;
  assign out_dir     = dir_reg;
  assign out_key     = key_reg;
`ifdef BITONIC_MERGE_PAYLOAD_EN
  assign out_payload = payload_reg;
`endif

endmodule

// File: rtl/bitonic_merge_pipe.sv
// Pipelined bitonic merger with valid/ready flow control and per-beat direction.
// Define BITONIC_MERGE_PAYLOAD_EN to carry a payload word alongside every key.
module bitonic_merge_pipe
  import bitonic_pkg::*;
#(
  parameter int  VALUE_BITS   = 8,
  parameter int  DEPTH        = 3,
  parameter int  PAYLOAD_BITS = 8,
  localparam int SIZE         = 1 << DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_dir,
  input  logic [SIZE*VALUE_BITS-1:0]   in_key,
`ifdef BITONIC_MERGE_PAYLOAD_EN
  input  logic [SIZE*PAYLOAD_BITS-1:0] in_payload,
  output logic [SIZE*PAYLOAD_BITS-1:0] out_payload,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_dir,
  output logic [SIZE*VALUE_BITS-1:0]   out_key
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH || PAYLOAD_BITS < 1) begin : g_bad_cfg
    $error("bitonic_merge_pipe: DEPTH must be 1..%0d and PAYLOAD_BITS positive", MAX_DEPTH);
  end

  logic [SIZE*VALUE_BITS-1:0] key_chain [DEPTH+1];
  logic [DEPTH:0]             valid_chain;
  logic [DEPTH:0]             dir_chain;
  logic                       adv;
`ifdef BITONIC_MERGE_PAYLOAD_EN
  logic [SIZE*PAYLOAD_BITS-1:0] payload_chain [DEPTH+1];
  assign payload_chain[0] = in_payload;
  assign out_payload      = payload_chain[DEPTH];
`endif

  // One global enable: the whole pipe moves unless the output beat is blocked.
  assign adv            = out_ready | ~valid_chain[DEPTH];
  assign in_ready       = adv;
  assign valid_chain[0] = in_valid & adv;
  assign dir_chain[0]   = in_dir;
  assign key_chain[0]   = in_key;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    bitonic_merge_stage #(
      .VALUE_BITS   (VALUE_BITS),
      .SIZE         (SIZE),
      .HALF         (SIZE >> (gi + 1))
`ifdef BITONIC_MERGE_PAYLOAD_EN
      ,
      .PAYLOAD_BITS (PAYLOAD_BITS)
`endif
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (adv),
      .in_valid    (valid_chain[gi]),
      .in_dir      (dir_chain[gi]),
      .in_key      (key_chain[gi]),
`ifdef BITONIC_MERGE_PAYLOAD_EN
      .in_payload  (payload_chain[gi]),
      .out_payload (payload_chain[gi+1]),
`endif
      .out_valid   (valid_chain[gi+1]),
      .out_dir     (dir_chain[gi+1]),
      .out_key     (key_chain[gi+1])
    );
  end

  assign out_valid = valid_chain[DEPTH];
  assign out_dir   = dir_chain[DEPTH];
  assign out_key   = key_chain[DEPTH];

endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// Scoreboard bench for bitonic_merge_pipe: expected beats are queued at acceptance,
// a monitor pops them when the DUT emits. Payload checks follow BITONIC_MERGE_PAYLOAD_EN.
module tb_bitonic_merge_pipe;

  localparam int VB    = 8;
  localparam int DEPTH = 3;
  localparam int PB    = 8;
  localparam int SIZE  = 1 << DEPTH;
  localparam int KW    = SIZE * VB;
  localparam int PW    = SIZE * PB;

  typedef struct {
    logic [KW-1:0] in_key;
    logic [KW-1:0] exp_key;
    logic          dir;
    int            acc_cyc;
    bit            perm_only;
    logic [PW-1:0] in_pay;
    bit            exact_pay;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_dir;
  logic [KW-1:0] in_key;
  logic          out_valid;
  logic          out_ready;
  logic          out_dir;
  logic [KW-1:0] out_key;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   lat_check = 1'b0;
  bit   rand_bp   = 1'b0;

  bitonic_merge_pipe #(.VALUE_BITS(VB), .DEPTH(DEPTH), .PAYLOAD_BITS(PB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dir      (in_dir),
    .in_key      (in_key),
`ifdef BITONIC_MERGE_PAYLOAD_EN
    .in_payload  (in_payload),
    .out_payload (out_payload),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_dir     (out_dir),
    .out_key     (out_key)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: the merged beat is simply the full sort of the input keys.
  function automatic logic [KW-1:0] sort_vec(input logic [KW-1:0] v, input logic d);
    int            q[$];
    logic [KW-1:0] r;
    for (int i = 0; i < SIZE; i++) q.push_back(int'(v[i*VB +: VB]));
    q.sort();
    if (d) q.reverse();
    r = '0;
    for (int i = 0; i < SIZE; i++) r[i*VB +: VB] = VB'(q[i]);
    return r;
  endfunction

  function automatic logic [KW-1:0] pack_keys(input int a[SIZE]);
    logic [KW-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*VB +: VB] = VB'(a[i]);
    return r;
  endfunction

  // Random bitonic vector: sorted values split into a rising run then a falling run.
  function automatic logic [KW-1:0] gen_bitonic();
    int            s[$];
    int            lft[$];
    int            rgt[$];
    int            hi;
    logic [KW-1:0] r;
    hi = ($urandom_range(0, 3) == 0) ? 3 : 255;
    for (int i = 0; i < SIZE; i++) s.push_back(int'($urandom_range(0, hi)));
    s.sort();
    foreach (s[i]) begin
      if ($urandom_range(0, 1) == 1) lft.push_back(s[i]);
      else rgt.push_front(s[i]);
    end
    foreach (rgt[i]) lft.push_back(rgt[i]);
    if ($urandom_range(0, 1) == 1) lft.reverse();
    for (int i = 0; i < SIZE; i++) r[i*VB +: VB] = VB'(lft[i]);
    return r;
  endfunction

  function automatic bit pairs_ok(input logic [KW-1:0] ki, input logic [PW-1:0] pi,
                                  input logic [KW-1:0] ko, input logic [PW-1:0] po);
    bit used[SIZE];
    bit found;
    for (int i = 0; i < SIZE; i++) used[i] = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      found = 1'b0;
      for (int j = 0; j < SIZE; j++) begin
        if (!found && !used[j] && ko[i*VB +: VB] == ki[j*VB +: VB] &&
            po[i*PB +: PB] == pi[j*PB +: PB]) begin
          used[j] = 1'b1;
          found   = 1'b1;
        end
      end
      if (!found) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor: compares every taken beat and checks stability across stalls.
  initial begin
    bit            prev_stall;
    logic [KW-1:0] prev_key;
    logic          prev_dir;
    exp_t          e;
    prev_stall = 1'b0;
    prev_key   = '0;
    prev_dir   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", 128'(out_valid), 128'(1));
        check("stall_key", 128'(out_key), 128'(prev_key));
        check("stall_dir", 128'(out_dir), 128'(prev_dir));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got key %0h with empty scoreboard (cycle %0d)", out_key, cyc);
        end else begin
          e = sb.pop_front();
          if (e.perm_only) check("perm_key", 128'(sort_vec(out_key, 1'b0)), 128'(sort_vec(e.in_key, 1'b0)));
          else check("out_key", 128'(out_key), 128'(e.exp_key));
          check("out_dir", 128'(out_dir), 128'(e.dir));
          if (lat_check) check("latency", 128'(cyc - e.acc_cyc), 128'(DEPTH));
`ifdef BITONIC_MERGE_PAYLOAD_EN
          if (e.exact_pay) check("payload_order", 128'(out_payload), 128'(e.in_pay));
          else check("payload_pairs", 128'(pairs_ok(e.in_key, e.in_pay, out_key, out_payload)), 128'(1));
`endif
          $display("beat key=%h dir=%0d cycle=%0d", out_key, out_dir, cyc);
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_key   = out_key;
      prev_dir   = out_dir;
    end
  end

  // Random downstream backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [KW-1:0] k, input logic d, input bit perm,
                      input logic [PW-1:0] p, input bit exact);
    exp_t e;
    int   waited;
    bit   took;
    in_valid   = 1'b1;
    in_key     = k;
    in_dir     = d;
    in_payload = p;
    waited     = 0;
    took       = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        took = 1'b1;
        break;
      end
      waited++;
      if (waited > 1000) begin
        check("accept_timeout", 128'(0), 128'(1));
        break;
      end
      @(posedge clk);
      #1;
    end
    if (took) begin
      e.in_key    = k;
      e.exp_key   = sort_vec(k, d);
      e.dir       = d;
      e.acc_cyc   = cyc;
      e.perm_only = perm;
      e.in_pay    = p;
      e.exact_pay = exact;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(sb.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            dk[SIZE];
    int            pk[SIZE];
    logic [KW-1:0] k;
    logic [PW-1:0] p;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_dir     = 1'b0;
    in_key     = '0;
    in_payload = '0;
    out_ready  = 1'b1;

    @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed ascending / descending on the reference vector.
    lat_check = 1'b1;
    dk = '{1, 4, 6, 9, 8, 5, 3, 2};
    k  = pack_keys(dk);
    for (int i = 0; i < SIZE; i++) p[i*PB +: PB] = PB'(i);
    send(k, 1'b0, 1'b0, p, 1'b0);
    wait_drain();
    send(k, 1'b1, 1'b0, p, 1'b0);
    wait_drain();

    // Back-to-back, alternating direction.
    for (int b = 0; b < 3; b++) send(gen_bitonic(), 1'(b), 1'b0, PW'($urandom), 1'b0);
    wait_drain();

    // Backpressure with three beats in flight.
    lat_check = 1'b0;
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) send(gen_bitonic(), 1'(b + 1), 1'b0, PW'($urandom), 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_out_valid", 128'(out_valid), 128'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Reset with two beats in flight, then a fresh beat with exact latency.
    lat_check = 1'b1;
    send(gen_bitonic(), 1'b0, 1'b0, PW'($urandom), 1'b0);
    send(gen_bitonic(), 1'b1, 1'b0, PW'($urandom), 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_reset_idle", 128'(out_valid), 128'(0));
    end
    @(posedge clk);
    #1;
    send(gen_bitonic(), 1'b1, 1'b0, PW'($urandom), 1'b0);
    wait_drain();

`ifdef BITONIC_MERGE_PAYLOAD_EN
    // All keys equal: no swap anywhere, payload order must survive both directions.
    for (int i = 0; i < SIZE; i++) begin
      dk[i] = 5;
      pk[i] = i;
    end
    for (int i = 0; i < SIZE; i++) p[i*PB +: PB] = PB'(pk[i]);
    send(pack_keys(dk), 1'b0, 1'b0, p, 1'b1);
    send(pack_keys(dk), 1'b1, 1'b0, p, 1'b1);
    wait_drain();
`endif

    // Random traffic with random gaps and random backpressure.
    lat_check = 1'b0;
    rand_bp   = 1'b1;
    for (int b = 0; b < 150; b++) begin
      send(gen_bitonic(), 1'($urandom_range(0, 1)), 1'b0, PW'({$urandom, $urandom}), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    // Non-bitonic inputs only need to come out as a permutation.
    for (int b = 0; b < 10; b++) begin
      send(KW'({$urandom, $urandom}), 1'($urandom_range(0, 1)), 1'b1, PW'({$urandom, $urandom}), 1'b0);
    end
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    repeat (3) @(negedge clk);
    check("final_idle", 128'(out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitonic_merge_pipe.md
Name: bitonic_merge_pipe

Overview:
- Parametrised pipelined bitonic merger, successor to the free-running recursive merger.
- Adds a valid/ready stream handshake with global backpressure, a synchronous reset, a per-beat runtime sort direction and an optional per-element payload.
- Sits after the bitonic sorter halves in the sort network: takes one bitonic vector of 2^DEPTH keys per beat and emits it fully ordered.

Parameters:
- VALUE_BITS, 8: key width in bits.
- DEPTH, 3: log2 of element count. Legal range 1..6.
- PAYLOAD_BITS, 8: payload width per element; used only when the payload feature is compiled in.
- SIZE, 1<<DEPTH: derived element count; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  merger accepts a beat this cycle.
- in_dir  in  1  0 = ascending (index 0 smallest), 1 = descending.
- in_key  in  SIZE*VALUE_BITS  bitonic key vector, element i at bits [i*VALUE_BITS +: VALUE_BITS].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_dir  out  1  direction the beat was merged with.
- out_key  out  SIZE*VALUE_BITS  ordered key vector.

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n. Polarity and synchronicity are fixed.
- Pipeline has DEPTH register stages. Stage s (s = 0..DEPTH-1) uses half = SIZE>>(s+1).
- In stage s, within each block of 2*half elements, element j is compare-exchanged with element j+half.
- Ascending: the lower index takes the smaller key. Descending: the lower index takes the larger key.
- Tie (keys equal): no swap. The lower index keeps its original element; this is observable with payload.
- Direction is latched per beat and travels with the data. Beats of mixed direction may be in flight together.
- Each stage holds a valid bit. All stages advance together when adv = out_ready | ~out_valid.
- in_ready = adv, combinational from out_ready and last-stage valid.
- Input handshake: a beat enters stage 0 when in_valid & in_ready. When adv is high and no beat enters, stage 0 captures valid=0 (a bubble).
- Bubbles are not collapsed: a bubble still occupies a stage.
- Latency is exactly DEPTH cycles from acceptance to out_valid when never stalled. Throughput is 1 beat/cycle.
- Stall (out_valid & ~out_ready): every stage holds its data, valid and dir. out_key and out_dir remain stable while out_valid is high and the beat has not been taken.
- Key and dir registers need no reset. All valid bits reset to 0.
- Reset values: out_valid=0. in_ready=1 in the reset cycle. out_key and out_dir are don't-care while out_valid=0.
- Reset mid-operation: all in-flight beats are discarded. No partial output is emitted after rst_n is released.
- Non-bitonic input: output is some permutation of the input, order unspecified. No error is flagged.
- Keys compare unsigned, at full VALUE_BITS width.

Optional Feature:
- Macro: BITONIC_MERGE_PAYLOAD_EN.
- Defined: adds ports in_payload and out_payload, each SIZE*PAYLOAD_BITS wide. Payload i moves with key i through every swap. Payload is held during stalls.
- Undefined: no payload ports and no payload registers. Behaviour is otherwise identical.

Decomposition:
- Package bitonic_pkg: typedef dir_e (DIR_ASC=0, DIR_DESC=1).
- Package bitonic_pkg: compare-exchange function cmp_swap(a, b, dir) returning the ordered pair, with the tie rule defined above.
- Package bitonic_pkg: localparam MAX_DEPTH=6.
- Sub-module bitonic_merge_stage (params VALUE_BITS, SIZE, HALF): one register stage holding its valid, dir and enable. Instantiated DEPTH times in a generate loop.

Test Plan (VALUE_BITS=8, DEPTH=3):
- Ascending, no stall: in_key [1,4,6,9,8,5,3,2] (index 0 first), in_dir=0 -> out_valid 3 cycles later with [1,2,3,4,5,6,8,9], out_dir=0.
- Descending: same keys with in_dir=1 -> [9,8,6,5,4,3,2,1].
- Back-to-back: 3 beats on consecutive cycles with alternating dir, out_ready=1 -> 3 consecutive out_valid cycles, each ordered per its own dir.
- Backpressure: out_ready held low for 5 cycles with 3 beats in flight -> in_ready=0, out_key stable. After release the beats drain in order, none lost or duplicated.
- Reset mid-flight: rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 on the following cycles; next accepted beat emerges 3 cycles after acceptance.
- Payload (macro defined): keys [5,5,5,5,5,5,5,5] with payload [0..7] -> payload order unchanged, [0,1,2,3,4,5,6,7].
